// File: rtl/dic_pkg.sv
// Shared definitions for the dic display transmitter.
// Holds ASCII constants, the transmit FSM state type, the base frame length
// and the snapshot record captured at the start of each frame.
package dic_pkg;

    localparam logic [7:0] CHR_0     = 8'h30;
    localparam logic [7:0] CHR_COLON = 8'h3A;
    localparam logic [7:0] CHR_SPACE = 8'h20;
    localparam logic [7:0] CHR_QMARK = 8'h3F;
    localparam logic [7:0] CHR_T     = 8'h54;
    localparam logic [7:0] CHR_A     = 8'h41;
    localparam logic [7:0] CHR_R     = 8'h52;
    localparam logic [7:0] CHR_S     = 8'h53;
    localparam logic [7:0] CHR_AT    = 8'h40;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;

    // Characters in a frame without the optional trailing LF.
    localparam int unsigned FRAME_LEN_BASE = 9;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } tx_state_t;

    // Everything a frame is built from, frozen when the frame starts.
    typedef struct packed {
        logic [3:0] mtens;
        logic [3:0] mones;
        logic [3:0] stens;
        logic [3:0] sones;
        logic       run;
        logic       alarm_ena;
        logic       ld_time;
        logic       ld_alarm;
    } snap_t;

endpackage

// File: rtl/dic_bcd2ascii.sv
// Combinational BCD digit to ASCII converter.
// Ports:
//   bcd   - 4-bit BCD digit
//   ascii - '0'..'9' for digits 0..9, '?' for 10..15
module dic_bcd2ascii
    import dic_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] ascii
);

    always_comb begin
        if (bcd <= 4'd9) begin
            ascii = CHR_0 + {4'h0, bcd};
        end else begin
            ascii = CHR_QMARK;
        end
    end

endmodule

// File: rtl/dic_disp_tx.sv
// Serialises a snapshot of the clock/alarm state as an ASCII status line
// ("MM:SS XY\r", optionally followed by "\n") over a byte valid/ready link.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   send_req            - request one frame (coalesced while busy)
//   mtens/mones/stens/sones - BCD digits to report
//   dicRun, alarm_ena, ld_time, ld_alarm - mode flags to report
//   tx_ready            - UART transmitter accepts a byte this cycle
//   tx_data, tx_valid   - byte offered to the UART
//   busy                - frame bytes are being offered
//   frame_done          - one-cycle pulse after the last byte is accepted
module dic_disp_tx
    import dic_pkg::*;
#(
    parameter bit EOL_LF = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_req,
    input  logic [3:0] mtens,
    input  logic [3:0] mones,
    input  logic [3:0] stens,
    input  logic [3:0] sones,
    input  logic       dicRun,
    input  logic       alarm_ena,
    input  logic       ld_time,
    input  logic       ld_alarm,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned FRAME_LEN = FRAME_LEN_BASE + (EOL_LF ? 1 : 0);
    localparam logic [3:0]  LAST_IDX  = 4'(FRAME_LEN - 1);

    tx_state_t  state;
    logic [3:0] idx;
    logic       pending;
    snap_t      snap;

    logic [7:0] mtens_chr, mones_chr, stens_chr, sones_chr;
    logic [7:0] status_chr, alarm_chr, frame_chr;
    logic [3:0] sel;

    dic_bcd2ascii u_mtens (.bcd(snap.mtens), .ascii(mtens_chr));
    dic_bcd2ascii u_mones (.bcd(snap.mones), .ascii(mones_chr));
    dic_bcd2ascii u_stens (.bcd(snap.stens), .ascii(stens_chr));
    dic_bcd2ascii u_sones (.bcd(snap.sones), .ascii(sones_chr));

    always_comb begin
        if (snap.ld_time) begin
            status_chr = CHR_T;
        end else if (snap.ld_alarm) begin
            status_chr = CHR_A;
        end else if (snap.run) begin
            status_chr = CHR_R;
        end else begin
            status_chr = CHR_S;
        end
        alarm_chr = snap.alarm_ena ? CHR_AT : CHR_SPACE;
    end

    // LOAD fetches character 0; in SEND the mux looks one ahead so the next
    // byte can be registered on the accepting edge without a bubble.
    assign sel = (state == SEND) ? idx + 4'd1 : 4'd0;

    always_comb begin
        case (sel)
            4'd0:    frame_chr = mtens_chr;
            4'd1:    frame_chr = mones_chr;
            4'd2:    frame_chr = CHR_COLON;
            4'd3:    frame_chr = stens_chr;
            4'd4:    frame_chr = sones_chr;
            4'd5:    frame_chr = CHR_SPACE;
            4'd6:    frame_chr = status_chr;
            4'd7:    frame_chr = alarm_chr;
            4'd8:    frame_chr = CHR_CR;
            default: frame_chr = CHR_LF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= 4'd0;
            pending    <= 1'b0;
            snap       <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (send_req || pending) begin
                        snap    <= '{mtens: mtens, mones: mones, stens: stens, sones: sones,
                                     run: dicRun, alarm_ena: alarm_ena,
                                     ld_time: ld_time, ld_alarm: ld_alarm};
                        idx     <= 4'd0;
                        pending <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (send_req) pending <= 1'b1;
                    tx_data  <= frame_chr;
                    tx_valid <= 1'b1;
                    busy     <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (send_req) pending <= 1'b1;
                    if (tx_ready) begin
                        if (idx == LAST_IDX) begin
                            tx_valid   <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx     <= idx + 4'd1;
                            tx_data <= frame_chr;
                        end
                    end
                end
                DONE: begin
                    if (send_req) pending <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dic_disp_tx.sv
// Self-checking bench for dic_disp_tx: one instance without and one with the
// trailing LF, both fed the same stimulus and checked against a frame-level
// reference model every cycle.
module tb_dic_disp_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       send_req;
    logic [3:0] mtens, mones, stens, sones;
    logic       dicRun, alarm_ena, ld_time, ld_alarm;
    logic       tx_ready;
    logic [7:0] tx_data    [2];
    logic       tx_valid   [2];
    logic       busy       [2];
    logic       frame_done [2];

    dic_disp_tx #(.EOL_LF(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .send_req(send_req),
        .mtens(mtens), .mones(mones), .stens(stens), .sones(sones),
        .dicRun(dicRun), .alarm_ena(alarm_ena), .ld_time(ld_time), .ld_alarm(ld_alarm),
        .tx_ready(tx_ready), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    dic_disp_tx #(.EOL_LF(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .send_req(send_req),
        .mtens(mtens), .mones(mones), .stens(stens), .sones(sones),
        .dicRun(dicRun), .alarm_ena(alarm_ena), .ld_time(ld_time), .ld_alarm(ld_alarm),
        .tx_ready(tx_ready), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a byte string built when it starts; after
    // one setup cycle its bytes are offered in order, one per accept, then a
    // single completion cycle with frame_done before the next frame can start.
    localparam int PH_IDLE = 0, PH_SETUP = 1, PH_OFFER = 2, PH_END = 3;
    int         m_phase [2];
    int         m_pos   [2];
    bit         m_pend  [2];
    logic [7:0] m_frame [2][10];
    int         m_len   [2] = '{9, 10};
    int         fd_count;

    function automatic logic [7:0] asc(input logic [3:0] d);
        return (d <= 4'd9) ? 8'h30 + {4'h0, d} : 8'h3F;
    endfunction

    task automatic build_frame(input int k);
        m_frame[k][0] = asc(mtens);
        m_frame[k][1] = asc(mones);
        m_frame[k][2] = ":";
        m_frame[k][3] = asc(stens);
        m_frame[k][4] = asc(sones);
        m_frame[k][5] = " ";
        m_frame[k][6] = ld_time ? "T" : ld_alarm ? "A" : dicRun ? "R" : "S";
        m_frame[k][7] = alarm_ena ? "@" : " ";
        m_frame[k][8] = 8'h0D;
        m_frame[k][9] = 8'h0A;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_phase[k] = PH_IDLE;
                m_pos[k]   = 0;
                m_pend[k]  = 1'b0;
            end else if (m_phase[k] == PH_IDLE) begin
                if (send_req || m_pend[k]) begin
                    build_frame(k);
                    m_pend[k]  = 1'b0;
                    m_phase[k] = PH_SETUP;
                end
            end else begin
                if (send_req) m_pend[k] = 1'b1;
                if (m_phase[k] == PH_SETUP) begin
                    m_pos[k]   = 0;
                    m_phase[k] = PH_OFFER;
                end else if (m_phase[k] == PH_OFFER) begin
                    if (tx_ready) begin
                        if (m_pos[k] == m_len[k] - 1) m_phase[k] = PH_END;
                        else m_pos[k]++;
                    end
                end else begin
                    m_phase[k] = PH_IDLE;
                end
            end
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("tx_valid%0d", k), 32'(tx_valid[k]), 32'(m_phase[k] == PH_OFFER));
            check_eq($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_phase[k] == PH_OFFER));
            check_eq($sformatf("frame_done%0d", k), 32'(frame_done[k]),
                     32'(m_phase[k] == PH_END));
            if (m_phase[k] == PH_OFFER) begin
                check_eq($sformatf("tx_data%0d[%0d]", k, m_pos[k]), 32'(tx_data[k]),
                         32'(m_frame[k][m_pos[k]]));
            end
        end
        if (frame_done[0]) fd_count++;
    endtask

    // Model the coming edge with the inputs now applied, then check the
    // outputs half a cycle after it.
    task automatic tick();
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic set_in(input logic [3:0] mt, input logic [3:0] mo, input logic [3:0] st,
                          input logic [3:0] so, input logic run, input logic ae,
                          input logic lt, input logic la);
        mtens = mt; mones = mo; stens = st; sones = so;
        dicRun = run; alarm_ena = ae; ld_time = lt; ld_alarm = la;
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        send_req = 1'b0;
        tx_ready = 1'b1;
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("reset_data0", 32'(tx_data[0]), 32'h00);
        check_eq("reset_data1", 32'(tx_data[1]), 32'h00);
        rst = 1'b1;
        tick();

        // "12:34 R@\r" with the receiver always ready.
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        pulse_req();
        repeat (14) tick();

        // "59:00 T \r\n" on the LF instance.
        set_in(4'd5, 4'd9, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_req();
        repeat (14) tick();

        // Receiver stalls in a 1,0,0 pattern.
        set_in(4'd2, 4'd7, 4'd1, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_req();
        for (int i = 0; i < 40; i++) begin
            tx_ready = (i % 3 == 0);
            tick();
        end
        tx_ready = 1'b1;

        // mones changes after byte 0 is accepted; the frame keeps '2'.
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_req();
        repeat (2) tick();
        mones = 4'd7;
        repeat (12) tick();

        // Three requests mid-frame collapse into one follow-up frame.
        fd_count = 0;
        set_in(4'd0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        pulse_req();
        for (int i = 0; i < 40; i++) begin
            send_req = (i == 2 || i == 4 || i == 6);
            if (i == 6) set_in(4'd4, 4'd5, 4'd5, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        send_req = 1'b0;
        check_eq("coalesced_frames", 32'(fd_count), 32'd2);

        // Out-of-range seconds-ones digit.
        set_in(4'd3, 4'd0, 4'd1, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_req();
        repeat (14) tick();

        // Reset while byte 4 is on the link, then stay quiet.
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        pulse_req();
        repeat (5) tick();
        check_eq("pre_reset_byte4", 32'(tx_data[0]), 32'h34);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (10) tick();

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            set_in(($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom_range(0, 9)),
                   ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom_range(0, 9)),
                   ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom_range(0, 5)),
                   ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom_range(0, 9)),
                   1'($urandom), 1'($urandom), ($urandom % 4 == 0), ($urandom % 4 == 0));
            send_req = ($urandom % 8 == 0);
            tx_ready = ($urandom % 3 != 0);
            rst      = ($urandom % 300 != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dic_disp_tx.md
Name: dic_disp_tx

Overview:
- Transmit-side counterpart to the clock control FSM.
- The FSM consumes decoded UART characters (digits, CR, '@', A/L/S). This block serialises the current clock or alarm state back out as an ASCII status line through a byte-wide valid/ready handshake into the UART transmitter.
- Each request snapshots the four BCD digits and the mode flags, then emits one fixed-format frame, for example "12:34 R@\r".

Parameters:
- EOL_LF, default 0: when 1, append LF (0x0A) after CR, so the frame is 10 characters instead of 9.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-low: rst==0 at a rising edge resets the block.
- send_req  in  1  single-cycle request to emit one frame.
- mtens  in  4  BCD minutes-tens digit.
- mones  in  4  BCD minutes-ones digit.
- stens  in  4  BCD seconds-tens digit.
- sones  in  4  BCD seconds-ones digit.
- dicRun  in  1  clock is running.
- alarm_ena  in  1  alarm is enabled.
- ld_time  in  1  time-load mode is active.
- ld_alarm  in  1  alarm-load mode is active.
- tx_ready  in  1  UART TX can accept a byte this cycle.
- tx_data  out  8  ASCII byte presented to the UART.
- tx_valid  out  1  tx_data is valid.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (rst==0): tx_valid=0, tx_data=8'h00, busy=0, frame_done=0, pending=0, char index=0, state=IDLE.
- Frame character order, index 0..8:
  - 0: ASCII(mtens)
  - 1: ASCII(mones)
  - 2: ':' (0x3A)
  - 3: ASCII(stens)
  - 4: ASCII(sones)
  - 5: ' ' (0x20)
  - 6: status character
  - 7: alarm character
  - 8: CR (0x0D)
  - 9: LF (0x0A), only when EOL_LF=1
- ASCII(d) = 0x30+d for d in 0..9. For d in 10..15 the byte is '?' (0x3F).
- Status character, in priority order:
  - ld_time=1 gives 'T' (0x54)
  - else ld_alarm=1 gives 'A' (0x41)
  - else dicRun=1 gives 'R' (0x52)
  - else 'S' (0x53)
- Alarm character: '@' (0x40) if alarm_ena=1, else ' ' (0x20).
- Snapshot: all 16 digit bits and 4 flag bits are registered on the edge that starts a frame. Input changes during the frame do not affect that frame.
- States:
  - IDLE: busy=0, tx_valid=0.
    - send_req=1 or pending=1 -> LOAD. Latch the snapshot, index=0, clear pending.
  - LOAD: exactly one cycle. Registers tx_data = char[0], tx_valid=1, busy=1. Go to SEND.
  - SEND: tx_valid and tx_data are held stable until tx_valid & tx_ready.
    - On each accept with index < last: index+1; the next char appears on the following edge with tx_valid still 1. Back-to-back bytes are allowed with no bubble.
    - On accept of the last char: tx_valid=0, frame_done=1 for one cycle, go to DONE.
  - DONE: exactly one cycle. busy=0. Go to IDLE.
- Latency: send_req in cycle n gives tx_valid=1 with char[0] in cycle n+2.
- tx_valid never deasserts mid-frame without a handshake; the transmitter may rely on this.
- send_req while busy (LOAD/SEND/DONE) sets pending (one-deep). Any number of extra requests coalesce into one follow-up frame. That frame starts from IDLE on the cycle after DONE and takes a fresh snapshot.
- send_req coinciding with the final handshake also sets pending.
- tx_ready=1 while tx_valid=0 is ignored.
- Reset mid-frame: all outputs return to reset values on that edge, pending is discarded, and no partial-frame continuation occurs.

Decomposition:
- Shared package dic_pkg holds:
  - ASCII constants: CHR_0, CHR_COLON, CHR_SPACE, CHR_QMARK, CHR_T, CHR_A, CHR_R, CHR_S, CHR_AT, CHR_CR, CHR_LF.
  - State enum: IDLE, LOAD, SEND, DONE.
  - FRAME_LEN_BASE=9.
- One sub-module: dic_bcd2ascii, combinational, 4-bit BCD in, 8-bit ASCII out, with '?' for out-of-range digits. It is instantiated four times.
- The character mux and the FSM stay in dic_disp_tx.

Test Plan:
- Digits 1,2,3,4, dicRun=1, alarm_ena=1, tx_ready=1 constant, send_req pulse -> bytes 31 32 3A 33 34 20 52 40 0D on 9 consecutive cycles, then frame_done pulse, then busy=0.
- Digits 5,9,0,0, ld_time=1, dicRun=0, alarm_ena=0, EOL_LF=1 -> bytes 35 39 3A 30 30 20 54 20 0D 0A.
- tx_ready toggling 1,0,0,1,... -> each byte is held stable while tx_ready=0; no byte is dropped or duplicated; order is unchanged.
- Change mones from 2 to 7 during the frame after byte 0 is sent -> byte 1 is still 0x32.
- Three send_req pulses during a frame -> exactly one follow-up frame, carrying the updated digits.
- Digit 4'hC on sones -> byte 4 = 0x3F.
- rst=0 asserted at byte 4 -> next edge tx_valid=0, busy=0; with no new send_req, tx_valid stays 0.
